// File: rtl/boot_seq_ctrl.sv
// Boot sequencer: holds the SoC in reset, optionally waits for a loader,
// enables instruction fetch, then watches GPIO for an exit code or a watchdog timeout.
module boot_seq_ctrl #(
  parameter int unsigned RST_HOLD_CYCLES = 10,
  parameter int unsigned FETCH_DELAY     = 4,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [1:0]  load_mode_i,
  input  logic        load_done_i,
  input  logic        load_err_i,
  input  logic [31:0] gpio_out_i,
  output logic        soc_rst_n_o,
  output logic        fetch_enable_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  exit_code_o,
  output logic [7:0]  gpio_code_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RST_HOLD  = 3'd1,
    S_LOAD_WAIT = 3'd2,
    S_FETCH_DLY = 3'd3,
    S_RUN       = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  localparam logic [1:0] EXIT_OK   = 2'b00;
  localparam logic [1:0] EXIT_FAIL = 2'b01;
  localparam logic [1:0] EXIT_NONE = 2'b10;
  localparam logic [1:0] EXIT_ERR  = 2'b11;

  // A zero-length phase still occupies one cycle, so the last count index is clamped at 0.
  localparam logic [31:0] HOLD_LAST  = (RST_HOLD_CYCLES == 0) ? 32'd0 : 32'(RST_HOLD_CYCLES - 1);
  localparam logic [31:0] FETCH_LAST = (FETCH_DELAY == 0) ? 32'd0 : 32'(FETCH_DELAY - 1);

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] wdog_q, wdog_d;
  logic [1:0]  exit_q, exit_d;
  logic [7:0]  gpio_code_q, gpio_code_d;
  logic        soc_rst_n_q, soc_rst_n_d;
  logic        fetch_en_q, fetch_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] wdog_inc;
  logic        wdog_hit;
  logic        unused_gpio;

  assign unused_gpio = ^gpio_out_i[31:8];

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    wdog_d      = wdog_q;
    exit_d      = exit_q;
    gpio_code_d = gpio_code_q;

    // Saturating increment; the limit compares against the value this cycle would reach.
    wdog_inc = (wdog_q == 32'hFFFF_FFFF) ? wdog_q : wdog_q + 32'd1;
    wdog_hit = (TIMEOUT_CYCLES != 32'd0) && (wdog_inc >= TIMEOUT_CYCLES);

    if (abort_i) begin
      state_d = S_IDLE;
      exit_d  = EXIT_NONE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_d = S_RST_HOLD;
            mode_d  = load_mode_i;
            cnt_d   = 32'd0;
            wdog_d  = 32'd0;
            exit_d  = EXIT_NONE;
          end
        end
        S_RST_HOLD: begin
          if (cnt_q >= HOLD_LAST) begin
            cnt_d   = 32'd0;
            state_d = (mode_q != 2'b00) ? S_LOAD_WAIT : S_FETCH_DLY;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_LOAD_WAIT: begin
          wdog_d = wdog_inc;
          if (load_err_i || wdog_hit) begin
            state_d = S_DONE;
            exit_d  = EXIT_ERR;
          end else if (load_done_i) begin
            state_d = S_FETCH_DLY;
          end
        end
        S_FETCH_DLY: begin
          wdog_d = wdog_inc;
          if (wdog_hit) begin
            state_d = S_DONE;
            exit_d  = EXIT_ERR;
          end else if (cnt_q >= FETCH_LAST) begin
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_RUN: begin
          wdog_d = wdog_inc;
          // GPIO completion outranks a watchdog hit in the same cycle.
          if (gpio_out_i[7]) begin
            state_d     = S_DONE;
            gpio_code_d = gpio_out_i[7:0];
            exit_d      = (gpio_out_i[7:0] == 8'hFF) ? EXIT_OK : EXIT_FAIL;
          end else if (wdog_hit) begin
            state_d = S_DONE;
            exit_d  = EXIT_ERR;
          end
        end
        default: begin
          state_d = S_IDLE;
          exit_d  = EXIT_NONE;
        end
      endcase
    end

    soc_rst_n_d = (state_d == S_LOAD_WAIT) || (state_d == S_FETCH_DLY) ||
                  (state_d == S_RUN) || (state_d == S_DONE);
    busy_d      = (state_d == S_RST_HOLD) || (state_d == S_LOAD_WAIT) ||
                  (state_d == S_FETCH_DLY) || (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
    // Fetch stays enabled into DONE only if the core was actually running.
    fetch_en_d  = (state_d == S_RUN) || ((state_d == S_DONE) && fetch_en_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'b00;
      cnt_q       <= 32'd0;
      wdog_q      <= 32'd0;
      exit_q      <= EXIT_NONE;
      gpio_code_q <= 8'h00;
      soc_rst_n_q <= 1'b0;
      fetch_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      wdog_q      <= wdog_d;
      exit_q      <= exit_d;
      gpio_code_q <= gpio_code_d;
      soc_rst_n_q <= soc_rst_n_d;
      fetch_en_q  <= fetch_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign soc_rst_n_o    = soc_rst_n_q;
  assign fetch_enable_o = fetch_en_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign exit_code_o    = exit_q;
  assign gpio_code_o    = gpio_code_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Directed bench for boot_seq_ctrl: default-parameter instance for the sequence
// cases, a TIMEOUT_CYCLES=50 instance for watchdog cases, sharing one stimulus.
module tb_boot_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [1:0]  load_mode_i = 2'b00;
  logic        load_done_i = 1'b0;
  logic        load_err_i = 1'b0;
  logic [31:0] gpio_out_i = 32'd0;

  logic        soc_rst_n_a, fetch_a, busy_a, done_a;
  logic [1:0]  exit_a;
  logic [7:0]  gcode_a;
  logic [2:0]  state_a;

  logic        soc_rst_n_b, fetch_b, busy_b, done_b;
  logic [1:0]  exit_b;
  logic [7:0]  gcode_b;
  logic [2:0]  state_b;

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  boot_seq_ctrl dut_a (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .load_mode_i(load_mode_i), .load_done_i(load_done_i), .load_err_i(load_err_i),
    .gpio_out_i(gpio_out_i), .soc_rst_n_o(soc_rst_n_a), .fetch_enable_o(fetch_a),
    .busy_o(busy_a), .done_o(done_a), .exit_code_o(exit_a), .gpio_code_o(gcode_a),
    .state_o(state_a)
  );

  boot_seq_ctrl #(.TIMEOUT_CYCLES(32'd50)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .load_mode_i(load_mode_i), .load_done_i(load_done_i), .load_err_i(load_err_i),
    .gpio_out_i(gpio_out_i), .soc_rst_n_o(soc_rst_n_b), .fetch_enable_o(fetch_b),
    .busy_o(busy_b), .done_o(done_b), .exit_code_o(exit_b), .gpio_code_o(gcode_b),
    .state_o(state_b)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled 1ns after each rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [1:0] mode);
    load_mode_i = mode;
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state_a), 32'd0);
    check({tag, "_socrst"}, 32'(soc_rst_n_a), 32'd0);
    check({tag, "_fetch"}, 32'(fetch_a), 32'd0);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_done"}, 32'(done_a), 32'd0);
    check({tag, "_exit"}, 32'(exit_a), 32'd2);
    check({tag, "_gcode"}, 32'(gcode_a), 32'd0);
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    check_reset_vals("rst0");

    // pass case, mode 10
    pulse_start(2'b10);
    check("pass_hold_state", 32'(state_a), 32'd1);
    check("pass_hold_busy", 32'(busy_a), 32'd1);
    check("pass_hold_socrst", 32'(soc_rst_n_a), 32'd0);
    step(9);
    check("pass_hold_end_socrst", 32'(soc_rst_n_a), 32'd0);
    step(1);
    check("pass_socrst_rise", 32'(soc_rst_n_a), 32'd1);
    check("pass_load_wait", 32'(state_a), 32'd2);
    step(19);
    load_done_i = 1'b1;
    step(1);
    load_done_i = 1'b0;
    check("pass_fdly_state", 32'(state_a), 32'd3);
    step(3);
    check("pass_fetch_early", 32'(fetch_a), 32'd0);
    step(1);
    check("pass_fetch_rise", 32'(fetch_a), 32'd1);
    check("pass_run_state", 32'(state_a), 32'd4);
    step(50);
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    check("run_start_ignored_state", 32'(state_a), 32'd4);
    check("run_start_ignored_fetch", 32'(fetch_a), 32'd1);
    step(48);
    gpio_out_i = 32'h0000_00FF;
    step(1);
    gpio_out_i = 32'd0;
    check("pass_done_state", 32'(state_a), 32'd5);
    check("pass_exit", 32'(exit_a), 32'd0);
    check("pass_gcode", 32'(gcode_a), 32'hFF);
    check("pass_done", 32'(done_a), 32'd1);
    check("pass_busy", 32'(busy_a), 32'd0);
    step(5);
    check("pass_hold_exit", 32'(exit_a), 32'd0);
    check("pass_hold_fetch", 32'(fetch_a), 32'd1);

    // restart from DONE
    pulse_start(2'b00);
    check("restart_state", 32'(state_a), 32'd1);
    check("restart_fetch", 32'(fetch_a), 32'd0);
    check("restart_socrst", 32'(soc_rst_n_a), 32'd0);
    check("restart_exit", 32'(exit_a), 32'd2);

    // fail case, mode 00: LOAD_WAIT skipped
    step(10);
    check("fail_skip_load", 32'(state_a), 32'd3);
    step(4);
    check("fail_run", 32'(state_a), 32'd4);
    gpio_out_i = 32'h0000_00A5;
    step(1);
    gpio_out_i = 32'd0;
    check("fail_state", 32'(state_a), 32'd5);
    check("fail_exit", 32'(exit_a), 32'd1);
    check("fail_gcode", 32'(gcode_a), 32'hA5);

    // load error wins over load done, mode 01
    pulse_start(2'b01);
    step(10);
    check("lerr_load_wait", 32'(state_a), 32'd2);
    load_done_i = 1'b1;
    load_err_i = 1'b1;
    step(1);
    load_done_i = 1'b0;
    load_err_i = 1'b0;
    check("lerr_state", 32'(state_a), 32'd5);
    check("lerr_exit", 32'(exit_a), 32'd3);
    check("lerr_fetch", 32'(fetch_a), 32'd0);
    step(3);
    check("lerr_fetch_hold", 32'(fetch_a), 32'd0);

    // abort in RUN
    pulse_start(2'b00);
    step(14);
    check("abort_pre_run", 32'(state_a), 32'd4);
    abort_i = 1'b1;
    step(1);
    abort_i = 1'b0;
    check("abort_state", 32'(state_a), 32'd0);
    check("abort_fetch", 32'(fetch_a), 32'd0);
    check("abort_exit", 32'(exit_a), 32'd2);
    check("abort_socrst", 32'(soc_rst_n_a), 32'd0);

    // reset in FETCH_DLY
    pulse_start(2'b00);
    step(12);
    check("rst_pre_fdly", 32'(state_a), 32'd3);
    do_reset();
    check_reset_vals("rst_fdly");

    // watchdog timeout on the 50-cycle instance
    pulse_start(2'b00);
    step(10);
    check("to_left_hold", 32'(state_b), 32'd3);
    step(49);
    check("to_not_yet", 32'(state_b), 32'd4);
    step(1);
    check("to_state", 32'(state_b), 32'd5);
    check("to_exit", 32'(exit_b), 32'd3);
    check("to_done", 32'(done_b), 32'd1);

    // timeout coinciding with GPIO 0xFF: GPIO wins
    do_reset();
    pulse_start(2'b00);
    step(59);
    check("tog_not_yet", 32'(state_b), 32'd4);
    gpio_out_i = 32'h0000_00FF;
    step(1);
    gpio_out_i = 32'd0;
    check("tog_state", 32'(state_b), 32'd5);
    check("tog_exit", 32'(exit_b), 32'd0);
    check("tog_gcode", 32'(gcode_b), 32'hFF);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/boot_seq_ctrl.md
BOOT_SEQ_CTRL -- requirements
Module: boot_seq_ctrl

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, default 10, meaning the number of cycles the SoC reset is held after start.
REQ-002 SHALL have parameter FETCH_DELAY, default 4, meaning the cycles from load completion to fetch enable.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000 (32-bit), meaning the watchdog limit; 0 disables the watchdog.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start_i, input, 1 bit: begins a boot sequence.
REQ-007 SHALL have port abort_i, input, 1 bit: returns the block to IDLE.
REQ-008 SHALL have port load_mode_i, input, 2 bits: 00 = standalone (no load), 01 = preload, 10 = SPI, 11 = reserved (treated as 10).
REQ-009 SHALL have port load_done_i, input, 1 bit: the loader has finished.
REQ-010 SHALL have port load_err_i, input, 1 bit: the loader has failed.
REQ-011 SHALL have port gpio_out_i, input, 32 bits: SoC GPIO outputs.
REQ-012 SHALL have port soc_rst_n_o, output, 1 bit: SoC reset, active-low.
REQ-013 SHALL have port fetch_enable_o, output, 1 bit: core fetch enable.
REQ-014 SHALL have port busy_o, output, 1 bit: high in RST_HOLD, LOAD_WAIT, FETCH_DLY and RUN.
REQ-015 SHALL have port done_o, output, 1 bit: level, high in DONE.
REQ-016 SHALL have port exit_code_o, output, 2 bits: 00 = success, 01 = fail, 10 = none, 11 = error/timeout.
REQ-017 SHALL have port gpio_code_o, output, 8 bits: gpio_out_i[7:0] captured at completion.
REQ-018 SHALL have port state_o, output, 3 bits: FSM state encoding (IDLE = 0, RST_HOLD = 1, LOAD_WAIT = 2, FETCH_DLY = 3, RUN = 4, DONE = 5).

Function
REQ-019 SHALL implement FSM states IDLE, RST_HOLD, LOAD_WAIT, FETCH_DLY, RUN and DONE; all outputs registered.
REQ-020 SHALL, in IDLE, drive soc_rst_n_o=0 and fetch_enable_o=0; start_i=1 moves to RST_HOLD, samples load_mode_i, clears all counters, and sets exit_code_o=10.
REQ-021 SHALL, in RST_HOLD, keep soc_rst_n_o=0 for exactly RST_HOLD_CYCLES cycles; then go to LOAD_WAIT if the sampled mode is not 00, else to FETCH_DLY.
REQ-022 SHALL drive soc_rst_n_o=1 in LOAD_WAIT, FETCH_DLY, RUN and DONE.
REQ-023 SHALL, in LOAD_WAIT, go to FETCH_DLY on load_done_i=1, or to DONE with exit_code_o=11 on load_err_i=1; load_err_i wins if both are high in the same cycle.
REQ-024 SHALL, in FETCH_DLY, wait exactly FETCH_DELAY cycles, then set fetch_enable_o=1 and go to RUN.
REQ-025 SHALL, in RUN, on gpio_out_i[7]=1, capture gpio_out_i[7:0] into gpio_code_o and go to DONE, with exit_code_o=00 if the byte equals 0xFF, else 01.
REQ-026 SHALL run a 32-bit watchdog counter that increments each cycle in LOAD_WAIT, FETCH_DLY and RUN; on reaching TIMEOUT_CYCLES (when nonzero), go to DONE with exit_code_o=11.
REQ-027 SHALL give priority to GPIO completion (REQ-025) over the watchdog when both occur in the same cycle.
REQ-028 SHALL saturate the watchdog counter at 0xFFFFFFFF, with no wrap.
REQ-029 SHALL, in DONE, hold fetch_enable_o, exit_code_o and gpio_code_o stable; start_i restarts the sequence at RST_HOLD, with fetch_enable_o=0 in the same transition.
REQ-030 SHALL ignore start_i in RST_HOLD, LOAD_WAIT, FETCH_DLY and RUN.
REQ-031 SHALL, on abort_i=1 in any state, go to IDLE the next cycle with IDLE outputs and exit_code_o=10; abort_i has priority over start_i and over all other transitions.
REQ-032 SHALL ignore load_done_i and load_err_i outside LOAD_WAIT.
REQ-033 SHALL treat RST_HOLD_CYCLES=0 or FETCH_DELAY=0 as one cycle in that state.

Reset
REQ-034 SHALL, with rst=1 at a clk edge, force IDLE, soc_rst_n_o=0, fetch_enable_o=0, busy_o=0, done_o=0, exit_code_o=10, gpio_code_o=0x00, state_o=0, and clear all counters.
REQ-035 SHALL, on reset asserted mid-sequence (any state), abandon the sequence with the same result as REQ-034, with no residual done_o or fetch_enable_o.

Verification
REQ-036 SHALL cover the pass case: mode=10, start; load_done_i 20 cycles after soc_rst_n_o rises; gpio_out_i=0x000000FF 100 cycles later -> soc_rst_n_o rises 10 cycles after start, fetch_enable_o rises 4 cycles after load_done_i, exit_code_o=00, gpio_code_o=FF, done_o=1.
REQ-037 SHALL cover the fail case: mode=00, start, gpio_out_i=0x000000A5 -> LOAD_WAIT skipped, exit_code_o=01, gpio_code_o=A5.
REQ-038 SHALL cover the load error case: mode=01, load_done_i and load_err_i high in the same cycle -> DONE, exit_code_o=11, fetch_enable_o stays 0.
REQ-039 SHALL cover the timeout case: TIMEOUT_CYCLES=50, mode=00, gpio_out_i[7] held 0 -> DONE exactly 50 watchdog cycles after leaving RST_HOLD, exit_code_o=11; separately, timeout coinciding with gpio_out_i[7:0]=FF -> exit_code_o=00.
REQ-040 SHALL cover abort and reset: abort_i in RUN -> IDLE next cycle, fetch_enable_o=0, exit_code_o=10; rst=1 in FETCH_DLY -> all REQ-034 values the next cycle.
REQ-041 SHALL cover restart: start_i in DONE -> state_o=1, fetch_enable_o=0, soc_rst_n_o=0 the next cycle; start_i pulsed while in RUN -> no effect.
